// File: rtl/ser_to_par_buffer_if.sv
// ser_to_par_buffer_if: handshake bundle between a serial producer, the buffer and a parallel consumer.
// Params: WIDTH bits per element, N_OUTS elements per word.
// Signals: in_valid/in_ready/in_data (serial side), out_valid/out_ready/out_data/out_count (parallel side),
// flush (present only when S2P_FLUSH_EN is defined).
// Modports: master = environment driving the buffer inputs, slave = the buffer itself.
interface ser_to_par_buffer_if #(
  parameter int WIDTH  = 32,
  parameter int N_OUTS = 4
);
  localparam int CW = ($clog2(N_OUTS + 1) < 1) ? 1 : $clog2(N_OUTS + 1);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_OUTS*WIDTH-1:0]  out_data;
  logic [CW-1:0]            out_count;
`ifdef S2P_FLUSH_EN
  logic                     flush;
  modport master (output in_valid, in_data, out_ready, flush, input in_ready, out_valid, out_data, out_count);
  modport slave  (input in_valid, in_data, out_ready, flush, output in_ready, out_valid, out_data, out_count);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_count);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_count);
`endif
endinterface

// File: rtl/ser_to_par_buffer.sv
// ser_to_par_buffer: packs N_OUTS serial WIDTH-bit elements into one parallel word, first element in lane 0.
// Ports: clk, rst (async active-high), bus (ser_to_par_buffer_if.slave: serial in, parallel out, count).
// Macro S2P_FLUSH_EN adds the flush input, which emits a partial word with out_count = lanes filled.
module ser_to_par_buffer #(
  parameter int WIDTH  = 32,
  parameter int N_OUTS = 4
) (
  input logic               clk,
  input logic               rst,
  ser_to_par_buffer_if.slave bus
);
  localparam int CW = ($clog2(N_OUTS + 1) < 1) ? 1 : $clog2(N_OUTS + 1);
  localparam int IW = (N_OUTS > 1) ? $clog2(N_OUTS) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t                         r_state, w_state_n;
  logic [IW-1:0]                  r_wr_idx, w_idx_n;
  logic [N_OUTS-1:0][WIDTH-1:0]   r_lanes, w_lanes_n;
  logic [CW-1:0]                  r_count, w_count_n;
  logic                           w_in_xfer, w_out_xfer, w_last, w_flush;
  // While full, a new element is only accepted when the held word leaves in the same cycle.
  assign bus.in_ready  = !rst && (r_state == FILL || bus.out_ready);
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_lanes;
  assign bus.out_count = r_count;
  assign w_in_xfer     = bus.in_valid && bus.in_ready;
  assign w_out_xfer    = bus.out_valid && bus.out_ready;
  assign w_last        = (r_wr_idx == IW'(N_OUTS - 1));
`ifdef S2P_FLUSH_EN
  // Flush needs at least one element, either already stored or arriving now.
  assign w_flush = bus.flush && r_state == FILL && (r_wr_idx != '0 || w_in_xfer);
`else
  assign w_flush = 1'b0;
`endif
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_wr_idx;
    w_lanes_n = r_lanes;
    w_count_n = r_count;
    if (r_state == FILL) begin
      if (w_in_xfer) begin
        for (int k = 0; k < N_OUTS; k++)
          if (r_wr_idx == IW'(k)) w_lanes_n[k] = bus.in_data;
        w_idx_n = w_last ? '0 : r_wr_idx + IW'(1);
      end
      if ((w_in_xfer && w_last) || w_flush) begin
        w_state_n = FULL;
        w_idx_n   = '0;
        w_count_n = (w_in_xfer && w_last) ? CW'(N_OUTS) : CW'(r_wr_idx) + CW'(w_in_xfer);
      end
    end else if (w_out_xfer) begin
      w_state_n = FILL;
      w_idx_n   = '0;
      w_lanes_n = '0;
      w_count_n = '0;
      if (w_in_xfer) begin
        // With a single lane the incoming element is already a complete word.
        w_lanes_n[0] = bus.in_data;
        w_state_n    = (N_OUTS == 1) ? FULL : FILL;
        w_idx_n      = (N_OUTS == 1) ? '0 : IW'(1);
        w_count_n    = (N_OUTS == 1) ? CW'(N_OUTS) : '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FILL;
      r_wr_idx <= '0;
      r_lanes  <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_wr_idx <= w_idx_n;
      r_lanes  <= w_lanes_n;
      r_count  <= w_count_n;
    end
  end
endmodule

// File: tb/tb_ser_to_par_buffer.sv
// tb_ser_to_par_buffer: directed table-driven bench for ser_to_par_buffer (4x8 and 1x16 instances).
module tb_ser_to_par_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ser_to_par_buffer_if #(.WIDTH(8),  .N_OUTS(4)) bus_a ();
  ser_to_par_buffer_if #(.WIDTH(16), .N_OUTS(1)) bus_b ();
  ser_to_par_buffer #(.WIDTH(8),  .N_OUTS(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ser_to_par_buffer #(.WIDTH(16), .N_OUTS(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  int total = 0;
  int bad   = 0;
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [31:0] od;
    logic [2:0] oc;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive_a(input logic iv, input logic [7:0] d, input logic ordy);
    bus_a.in_valid  = iv;
    bus_a.in_data   = d;
    bus_a.out_ready = ordy;
  endtask
  task automatic expect_a(input string nm, input logic ir, input logic ov, input logic [31:0] od, input logic [2:0] oc);
    chk({nm, ".in_ready"},  bus_a.in_ready,  ir);
    chk({nm, ".out_valid"}, bus_a.out_valid, ov);
    chk({nm, ".out_data"},  bus_a.out_data,  od);
    chk({nm, ".out_count"}, bus_a.out_count, oc);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    v[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h00000011, 3'd0};
    v[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h00002211, 3'd0};
    v[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h00332211, 3'd0};
    v[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    v[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    v[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    v[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    v[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    v[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
    v[10] = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 32'h00000055, 3'd0};
    v[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 32'h00000055, 3'd0};
    v[12] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 32'h00006655, 3'd0};
    v[13] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 32'h00776655, 3'd0};
    v[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h88776655, 3'd4};
    v[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0};
    drive_a(1'b0, 8'h00, 1'b0);
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = 16'h0000;
    bus_b.out_ready = 1'b0;
`ifdef S2P_FLUSH_EN
    bus_a.flush = 1'b0;
    bus_b.flush = 1'b0;
`endif
    #1 rst = 1'b1;
    #6;
    expect_a("reset", 1'b0, 1'b0, 32'h0, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_a(v[i].iv, v[i].d, v[i].ordy);
      #1;
      expect_a($sformatf("vec%0d", i), v[i].ir, v[i].ov, v[i].od, v[i].oc);
      @(posedge clk);
      #1;
    end
    drive_a(1'b0, 8'h00, 1'b0);
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus_b.in_data = 16'(k);
      #1;
      chk($sformatf("n1.w%0d.valid", k), bus_b.out_valid, k > 1);
      chk($sformatf("n1.w%0d.data", k),  bus_b.out_data,  k > 1 ? k - 1 : 0);
      chk($sformatf("n1.w%0d.ready", k), bus_b.in_ready,  1'b1);
      tick;
    end
    bus_b.in_valid = 1'b0;
    #1;
    chk("n1.last.valid", bus_b.out_valid, 1'b1);
    chk("n1.last.data",  bus_b.out_data,  16'h0008);
    chk("n1.last.count", bus_b.out_count, 1'b1);
    tick;
    chk("n1.drained", bus_b.out_valid, 1'b0);
    bus_b.out_ready = 1'b0;
    drive_a(1'b1, 8'h01, 1'b0);
    tick;
    drive_a(1'b1, 8'h02, 1'b0);
    tick;
    drive_a(1'b0, 8'h00, 1'b0);
    #1;
    chk("prefill.data", bus_a.out_data, 32'h00000201);
    #1 rst = 1'b1;
    #1;
    expect_a("async_rst_fill", 1'b0, 1'b0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 8'hA1 + 8'(k), 1'b0);
      tick;
    end
    drive_a(1'b0, 8'h00, 1'b0);
    #1;
    expect_a("after_rst_word", 1'b0, 1'b1, 32'hA4A3A2A1, 3'd4);
    #1 rst = 1'b1;
    #1;
    expect_a("async_rst_hold", 1'b0, 1'b0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(1'b0, 8'h00, 1'b1);
    tick;
    expect_a("post_hold_rst", 1'b1, 1'b0, 32'h0, 3'd0);
    drive_a(1'b0, 8'h00, 1'b0);
`ifdef S2P_FLUSH_EN
    drive_a(1'b1, 8'h55, 1'b0);
    tick;
    drive_a(1'b1, 8'h66, 1'b0);
    tick;
    drive_a(1'b0, 8'h00, 1'b0);
    bus_a.flush = 1'b1;
    tick;
    bus_a.flush = 1'b0;
    expect_a("flush_partial", 1'b0, 1'b1, 32'h00006655, 3'd2);
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;
    bus_a.flush = 1'b1;
    tick;
    bus_a.flush = 1'b0;
    expect_a("flush_empty", 1'b1, 1'b0, 32'h0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 8'h10 * 8'(k + 1), 1'b0);
      bus_a.flush = (k == 3);
      tick;
    end
    bus_a.flush = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0);
    expect_a("flush_full", 1'b0, 1'b1, 32'h40302010, 3'd4);
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;
    expect_a("flush_no_extra", 1'b1, 1'b0, 32'h0, 3'd0);
    tick;
    chk("flush_no_extra2", bus_a.out_valid, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
